// File: rtl/pipeline_ctrl.sv
// 5-stage hazard/forwarding/ECALL-halt controller; stall/bubble/flush are combinational, forwarding selects registered on advance.
// Backpressure: mem_ready low freezes all shadow slots, forwarding selects and FSM state.
module pipeline_ctrl #(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_only,
  input  logic [4:0] id_rd,
  input  logic       id_write_enable,
  input  logic       id_load,
  input  logic       id_ecall,
  input  logic       ex_redirect,
  input  logic       mem_ready,
  input  logic       halt_clear,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       freeze,
  output logic       halted,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  slot_t  ex_slot, mem_slot, wb_slot, ex_next;
  state_t state, state_next;
  logic   hold;
  logic   issue;
  logic   ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic   load_use, ecall_halt, slots_empty;
  logic [1:0] fwd_a_next, fwd_b_next;

  function automatic logic hit(slot_t s, logic [4:0] r);
    return s.vld && s.we && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  assign ex_hit_rs1  = hit(ex_slot, id_rs1);
  assign ex_hit_rs2  = ~id_rs1_only & hit(ex_slot, id_rs2);
  assign mem_hit_rs1 = hit(mem_slot, id_rs1);
  assign mem_hit_rs2 = ~id_rs1_only & hit(mem_slot, id_rs2);
  assign load_use    = id_valid & ex_slot.ld & (ex_hit_rs1 | ex_hit_rs2);
  assign ecall_halt  = HALT_ON_ECALL & id_valid & id_ecall;
  assign slots_empty = ~(ex_slot.vld | mem_slot.vld | wb_slot.vld);
  assign freeze      = ~mem_ready;
  assign halted      = (state == HALT);
  assign issue       = id_valid & ~bubble_ex & ~stall_id;

  // WB contents only matter for occupancy while draining.
  logic unused_wb;
  assign unused_wb = ^{wb_slot.rd, wb_slot.we, wb_slot.ld};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else if (!freeze) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (ecall_halt && !ex_redirect && !freeze) state_next = DRAIN;
      DRAIN: begin
        if (ex_redirect)      state_next = RUN;
        else if (slots_empty) state_next = HALT;
      end
      HALT:    if (halt_clear) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    hold      = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (!reset_n) begin
      hold = 1'b0;
    end else if (freeze) begin
      hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (load_use || ecall_halt) begin
            hold      = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        DRAIN: begin
          if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else begin
            hold      = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        HALT: begin
          // Resume releases the held ECALL into EX in this same cycle.
          if (!halt_clear) begin
            hold      = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        default: hold = 1'b0;
      endcase
    end
    stall_if = hold;
    stall_id = hold;
  end

  always_comb begin
    ex_next    = '0;
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (issue) begin
      ex_next.vld = 1'b1;
      ex_next.rd  = id_rd;
      ex_next.we  = id_write_enable & ~id_ecall;
      ex_next.ld  = id_load;
      if (ex_hit_rs1)       fwd_a_next = 2'b01;
      else if (mem_hit_rs1) fwd_a_next = 2'b10;
      if (ex_hit_rs2)       fwd_b_next = 2'b01;
      else if (mem_hit_rs2) fwd_b_next = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
      fwd_a    <= 2'b00;
      fwd_b    <= 2'b00;
    end else if (!freeze) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= ex_next;
      fwd_a    <= fwd_a_next;
      fwd_b    <= fwd_b_next;
    end
  end

endmodule
